// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, valid/ready on both sides, result held until consumed.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// MUL   | shift-add multiply, XLEN iterations
// DIV   | restoring divide, XLEN iterations
// DONE  | result registered, waiting for out_ready
module alu_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUResult,
    output logic            divzerof,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state;
    logic [1:0]          op_q;
    logic                neg_q;
    logic [XLEN-1:0]     opb_q;
    logic [2*XLEN-1:0]   acc;
    logic [CNT_W-1:0]    cnt;

    logic                a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]     a_mag, b_mag, special_res;
    logic                is_div_zero, is_ovf;
    logic [XLEN:0]       add_sum;
    logic [2*XLEN-1:0]   mul_next, div_next, step_next, prod_fix;
    logic [XLEN:0]       part;
    logic [XLEN-1:0]     diff;
    logic                ge;
    logic [XLEN-1:0]     div_sel, fin_res;

    always_comb begin
        a_signed    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg       = a_signed && SrcA[XLEN-1];
        b_neg       = b_signed && SrcB[XLEN-1];
        a_mag       = a_neg ? -SrcA : SrcA;
        b_mag       = b_neg ? -SrcB : SrcB;
        // remainders take the dividend sign, everything else the XOR of signs
        neg_in      = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
        is_div_zero = op[2] && (SrcB == '0);
        is_ovf      = op[2] && !op[0] && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
        if (is_div_zero)
            special_res = op[1] ? SrcA : '1;
        else
            special_res = op[1] ? '0 : SrcA;
    end

    // acc = {high/remainder, multiplier/dividend-quotient}; opb_q = multiplicand/divisor
    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
        mul_next = {add_sum, acc[XLEN-1:1]};
        part     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        ge       = part >= {1'b0, opb_q};
        diff     = part[XLEN-1:0] - opb_q;
        div_next = ge ? {diff, acc[XLEN-2:0], 1'b1} : {part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        step_next = (state == MUL) ? mul_next : div_next;
        prod_fix = neg_q ? -step_next : step_next;
        div_sel  = op_q[1] ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
        if (state == MUL)
            fin_res = (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else
            fin_res = neg_q ? -div_sel : div_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            opb_q     <= '0;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ALUResult <= '0;
            divzerof  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q     <= op[1:0];
                        neg_q    <= neg_in;
                        opb_q    <= b_mag;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (is_div_zero || is_ovf) begin
                            ALUResult <= special_res;
                            divzerof  <= is_div_zero;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            acc      <= {{XLEN{1'b0}}, a_mag};
                            cnt      <= CNT_W'(XLEN);
                            divzerof <= 1'b0;
                            state    <= op[2] ? DIV : MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    acc <= step_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        ALUResult <= fin_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
